unified_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the fetch stage (read-only) and the memory stage (load/store) of the pipelined RV32I core.
- Grants one requester at a time and drives the memory request/ready handshake.
- Returns registered read data and per-requester stall signals to the pipeline control.
- Prefers data accesses to drain the pipeline. A streak limit keeps fetch from starving, and a timeout keeps a dead memory from hanging the core.

---
 rtl/unified_mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Brief    : Shares one single-ported unified memory between the RV32I fetch
//            stage (read-only) and memory stage (load/store). Data accesses
//            are preferred, a streak limit protects fetch from starvation and
//            a busy timeout protects the core from a dead memory.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              reset,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    // data port
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_valid,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    // pipeline stalls
    output logic              stall_if,
    output logic              stall_dm,
    // memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_IF_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DM_BUSY = 2'd2;

    // Timeout counter only needs to reach TIMEOUT-1; the abort fires on the
    // edge that would take it to TIMEOUT.
    localparam int              c_TW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int              c_TMO_LAST_I  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [c_TW-1:0] c_TMO_LAST    = c_TW'(c_TMO_LAST_I);
    localparam logic            c_TMO_EN      = (TIMEOUT > 0);
    localparam logic [3:0]      c_STREAK_MAX  = 4'(MAX_DM_STREAK);

    logic [1:0]      r_state;
    logic [3:0]      r_streak;
    logic [c_TW-1:0] r_timer;
    logic            r_discard;

    logic w_idle;
    logic w_busy;
    logic w_if_cand;
    logic w_grant_if;
    logic w_grant_dm;
    logic w_if_mis;
    logic w_dm_mis;
    logic w_done_ok;
    logic w_done_tmo;
    logic w_done;
    logic w_if_drop;

    // Arbitration and completion decode
    always_comb begin
        w_idle     = (r_state == c_ST_IDLE);
        w_busy     = (r_state == c_ST_IF_BUSY) || (r_state == c_ST_DM_BUSY);
        // a flushing fetch is not a candidate for the grant
        w_if_cand  = if_req & ~if_flush;
        w_grant_if = w_idle & w_if_cand & (~dm_req | (r_streak == c_STREAK_MAX));
        w_grant_dm = w_idle & dm_req & ~w_grant_if;
        w_if_mis   = |if_addr[1:0];
        w_dm_mis   = |dm_addr[1:0];
        // a real handshake wins over a coincident timeout
        w_done_ok  = w_busy & mem_ready;
        w_done_tmo = w_busy & ~mem_ready & c_TMO_EN & (r_timer == c_TMO_LAST);
        w_done     = w_done_ok | w_done_tmo;
        w_if_drop  = r_discard | if_flush;
    end

    // Pipeline stalls follow the request/valid handshake directly
    always_comb begin
        stall_if = if_req & ~if_valid;
        stall_dm = dm_req & ~dm_valid;
    end

    // Count consecutive data grants taken while fetch is waiting
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_streak <= 4'd0;
        end else if (!if_req || w_grant_if) begin
            r_streak <= 4'd0;
        end else if (w_grant_dm && (r_streak != 4'hF)) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    // Busy-cycle counter for the dead-memory timeout
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (w_grant_if || w_grant_dm) begin
            r_timer <= '0;
        end else if (w_busy && c_TMO_EN) begin
            r_timer <= r_timer + c_TW'(1);
        end
    end

    // Remember a flush that lands while a fetch is outstanding
    always_ff @(posedge clk) begin
        if (!reset || w_idle || w_done) begin
            r_discard <= 1'b0;
        end else if ((r_state == c_ST_IF_BUSY) && if_flush) begin
            r_discard <= 1'b1;
        end
    end

    // Main FSM: grant, memory handshake and registered responses
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            dm_valid  <= 1'b0;
            dm_rdata  <= '0;
            dm_err    <= 1'b0;
        end else begin
            // valid/err are single-cycle pulses
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            dm_valid <= 1'b0;
            dm_err   <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_dm) begin
                        if (w_dm_mis) begin
                            // rejected without touching memory
                            dm_valid <= 1'b1;
                            dm_err   <= 1'b1;
                            dm_rdata <= '0;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= dm_we;
                            mem_addr  <= {dm_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= dm_wdata;
                            r_state   <= c_ST_DM_BUSY;
                        end
                    end else if (w_grant_if) begin
                        if (w_if_mis) begin
                            if_valid <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= '0;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= '0;
                            r_state   <= c_ST_IF_BUSY;
                        end
                    end
                end

                c_ST_IF_BUSY: begin
                    if (w_done) begin
                        mem_req <= 1'b0;
                        r_state <= c_ST_IDLE;
                        // a flushed fetch still finishes the handshake silently
                        if (!w_if_drop) begin
                            if_valid <= 1'b1;
                            if_err   <= w_done_tmo;
                            if_rdata <= w_done_ok ? mem_rdata : 32'd0;
                        end
                    end
                end

                c_ST_DM_BUSY: begin
                    if (w_done) begin
                        mem_req  <= 1'b0;
                        r_state  <= c_ST_IDLE;
                        dm_valid <= 1'b1;
                        dm_err   <= w_done_tmo;
                        dm_rdata <= (w_done_ok && !mem_we) ? mem_rdata : 32'd0;
                    end
                end

                default: begin
                    mem_req <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_arbiter
// Brief    : Scoreboard bench for unified_mem_arbiter with a behavioural
//            single-ported memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, if_valid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_valid, dm_err;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        stall_if, stall_dm;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_exp_t exp_mem_q[$];
    resp_t    exp_dm_q[$];
    resp_t    exp_if_q[$];

    logic [31:0] mem_img [logic [31:0]];

    int n_checks = 0;
    int n_fail   = 0;

    int mem_lat      = 0;
    int lat_cnt      = 0;
    logic mem_dead     = 1'b0;
    logic inject_ready = 1'b0;

    logic     mon_prev_req = 1'b0;
    mem_exp_t mon_cur;

    unified_mem_arbiter #(
        .ADDR_W       (32),
        .MAX_DM_STREAK(4),
        .TIMEOUT      (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_valid (dm_valid),
        .dm_rdata (dm_rdata),
        .dm_err   (dm_err),
        .stall_if (stall_if),
        .stall_dm (stall_dm),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [31:0] wd);
        exp_mem_q.push_back('{addr: a, we: we, wdata: wd});
    endtask

    function automatic logic [31:0] read_img(input logic [31:0] a);
        return mem_img.exists(a) ? mem_img[a] : 32'hBAD0_0000;
    endfunction

    // Memory responder: mem_ready after mem_lat extra cycles, or on demand
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rdata = 32'd0;
            if (inject_ready) begin
                mem_ready    = 1'b1;
                mem_rdata    = 32'h0BAD_F00D;
                inject_ready = 1'b0;
            end else if (mem_req && !mem_dead) begin
                if (lat_cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = read_img(mem_addr);
                    lat_cnt   = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Memory-side monitor: every new request must match the next expected access
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && !mon_prev_req) begin
                if (exp_mem_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mem_req_unexpected: got access addr=%h we=%b, expected none", mem_addr, mem_we);
                    mon_cur = '{addr: mem_addr, we: mem_we, wdata: mem_wdata};
                end else begin
                    mon_cur = exp_mem_q.pop_front();
                    check("mem_addr", mem_addr, mon_cur.addr);
                    check("mem_we", mem_we, mon_cur.we);
                    check("mem_wdata", mem_wdata, mon_cur.wdata);
                end
            end else if (mem_req) begin
                check("mem_addr_stable", {mem_we, mem_wdata, mem_addr}, {mon_cur.we, mon_cur.wdata, mon_cur.addr});
            end
            mon_prev_req = mem_req;
        end
    end

    // Response monitor: each valid pulse pops and compares the scoreboard
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (if_valid && dm_valid) begin
                check("valid_exclusive", {if_valid, dm_valid}, 2'b01);
            end
            if (dm_valid) begin
                if (exp_dm_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dm_valid_unexpected: got rdata=%h err=%b, expected no response", dm_rdata, dm_err);
                end else begin
                    r = exp_dm_q.pop_front();
                    check("dm_rdata", dm_rdata, r.rdata);
                    check("dm_err", dm_err, r.err);
                end
            end
            if (if_valid) begin
                if (exp_if_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL if_valid_unexpected: got rdata=%h err=%b, expected no response", if_rdata, if_err);
                end else begin
                    r = exp_if_q.pop_front();
                    check("if_rdata", if_rdata, r.rdata);
                    check("if_err", if_err, r.err);
                end
            end
        end
    end

    task automatic dm_access(input logic we, input logic [31:0] a, input logic [31:0] wd, output int lat);
        lat = 0;
        dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
        do begin
            @(posedge clk); #1;
            lat++;
            check("stall_dm", stall_dm, !dm_valid);
        end while (!dm_valid && lat < 50);
        if (!dm_valid) begin
            n_checks++; n_fail++;
            $display("FAIL dm_wait: got no dm_valid in 50 cycles, expected a response");
        end
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    endtask

    task automatic if_access(input logic [31:0] a, output int lat);
        lat = 0;
        if_req = 1'b1; if_addr = a;
        do begin
            @(posedge clk); #1;
            lat++;
            check("stall_if", stall_if, !if_valid);
        end while (!if_valid && lat < 50);
        if (!if_valid) begin
            n_checks++; n_fail++;
            $display("FAIL if_wait: got no if_valid in 50 cycles, expected a response");
        end
        if_req = 1'b0; if_addr = '0;
    endtask

    task automatic wait_mem_req(input logic level, input string name);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (mem_req !== level && n < 30);
        check(name, mem_req, level);
    endtask

    localparam logic [31:0] c_DM_VALS [6] = '{32'h1111_0200, 32'h2222_0204, 32'h3333_0208,
                                              32'h4444_020C, 32'h5555_0210, 32'h6666_0214};

    initial begin
        int lat;
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        mem_img[32'h100]  = 32'hDEAD_BEEF;
        mem_img[32'h40]   = 32'hFFFF_FFFF;
        mem_img[32'h44]   = 32'h1234_0000;
        mem_img[32'h80]   = 32'h0000_0013;
        mem_img[32'h1000] = 32'h0010_0093;
        for (int i = 0; i < 6; i++) mem_img[32'h200 + 32'(4 * i)] = c_DM_VALS[i];

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_valids", {if_valid, dm_valid, if_err, dm_err}, 0);
        check("rst_rdata", {if_rdata, dm_rdata}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // load with minimum latency
        mem_lat = 0;
        push_mem(32'h100, 1'b0, 32'd0);
        exp_dm_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
        dm_access(1'b0, 32'h100, 32'd0, lat);
        check("load_latency", lat, 2);

        // misaligned store: no memory access, error next cycle
        exp_dm_q.push_back('{rdata: 32'd0, err: 1'b1});
        dm_access(1'b1, 32'h203, 32'hCAFE_F00D, lat);
        check("misaligned_latency", lat, 1);

        // aligned store
        push_mem(32'h204, 1'b1, 32'h1234_5678);
        exp_dm_q.push_back('{rdata: 32'd0, err: 1'b0});
        dm_access(1'b1, 32'h204, 32'h1234_5678, lat);
        check("store_latency", lat, 2);

        // misaligned fetch
        exp_if_q.push_back('{rdata: 32'd0, err: 1'b1});
        if_access(32'h42, lat);
        check("if_misaligned_latency", lat, 1);

        // streak: both held, expected grant order DM x4, IF, DM x2
        for (int i = 0; i < 4; i++) push_mem(32'h200 + 32'(4 * i), 1'b0, 32'd0);
        push_mem(32'h1000, 1'b0, 32'd0);
        for (int i = 4; i < 6; i++) push_mem(32'h200 + 32'(4 * i), 1'b0, 32'd0);
        for (int i = 0; i < 6; i++) exp_dm_q.push_back('{rdata: c_DM_VALS[i], err: 1'b0});
        exp_if_q.push_back('{rdata: 32'h0010_0093, err: 1'b0});
        fork
            begin
                int l;
                if_access(32'h1000, l);
                check("if_starved_wait", l, 10);
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    int n;
                    n = 0;
                    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200 + 32'(4 * i);
                    do begin
                        @(posedge clk); #1;
                        n++;
                    end while (!dm_valid && n < 50);
                    check("streak_dm_valid", dm_valid, 1);
                end
                dm_req = 1'b0; dm_addr = '0;
            end
        join

        // fetch flushed while busy, memory slow
        mem_lat = 3;
        push_mem(32'h40, 1'b0, 32'd0);
        if_req = 1'b1; if_addr = 32'h40;
        wait_mem_req(1'b1, "flush_mem_req_rise");
        if_flush = 1'b1; if_req = 1'b0; if_addr = '0;
        @(posedge clk); #1;
        if_flush = 1'b0;
        wait_mem_req(1'b0, "flush_mem_req_drop");
        repeat (2) @(posedge clk);
        #1;

        // following fetch returns normally
        push_mem(32'h80, 1'b0, 32'd0);
        exp_if_q.push_back('{rdata: 32'h0000_0013, err: 1'b0});
        if_access(32'h80, lat);
        check("slow_fetch_latency", lat, 5);

        // flush coinciding with completion
        mem_lat = 0;
        push_mem(32'h44, 1'b0, 32'd0);
        if_req = 1'b1; if_addr = 32'h44;
        wait_mem_req(1'b1, "flush2_mem_req_rise");
        if_flush = 1'b1; if_req = 1'b0; if_addr = '0;
        @(posedge clk); #1;
        if_flush = 1'b0;
        check("flush2_mem_req_drop", mem_req, 0);
        repeat (2) @(posedge clk);
        #1;

        // dead memory: timeout after 8 busy cycles, late ready ignored
        mem_dead = 1'b1;
        push_mem(32'h300, 1'b0, 32'd0);
        exp_dm_q.push_back('{rdata: 32'd0, err: 1'b1});
        dm_access(1'b0, 32'h300, 32'd0, lat);
        check("timeout_latency", lat, 9);
        check("timeout_mem_req", mem_req, 0);
        mem_dead = 1'b0;
        @(negedge clk);
        inject_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("late_ready_mem_req", mem_req, 0);

        // reset during DM_BUSY
        mem_lat = 5;
        push_mem(32'h400, 1'b1, 32'h5A5A_5A5A);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h400; dm_wdata = 32'h5A5A_5A5A;
        wait_mem_req(1'b1, "rst_busy_mem_req");
        reset = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        @(posedge clk); #1;
        check("midrst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        check("midrst_resp", {if_valid, dm_valid, if_err, dm_err}, 0);
        check("midrst_rdata", {if_rdata, dm_rdata}, 0);
        reset = 1'b1;
        @(negedge clk);
        inject_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("postrst_mem_req", mem_req, 0);

        // scoreboard must be drained
        check("pending_mem", exp_mem_q.size(), 0);
        check("pending_dm", exp_dm_q.size(), 0);
        check("pending_if", exp_if_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion before 200000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
